// File: rtl/fetch_router_axis.sv
// fetch_router_axis: AXI4-Stream slave that routes DMA beats to one of
// NUM_BANKS BRAM write ports. Addresses are generated in linear or
// column-major (transposed) order over a rows x cols tile. Packet length is
// checked against the tile size, and a per-bank done pulse follows each packet.
module fetch_router_axis #(
  parameter int NUM_BANKS  = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESET,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  input  logic                  S_AXIS_TLAST,
  output logic                  S_AXIS_TREADY,
  input  logic                  enable,
  input  logic [SEL_WIDTH-1:0]  bank_sel,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  rows,
  input  logic [DIM_WIDTH-1:0]  cols,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic [NUM_BANKS-1:0]  bram_we,
  output logic [NUM_BANKS-1:0]  done,
  output logic                  ovf_err,
  output logic                  short_err,
  output logic                  sel_err
);

  localparam int PW = 2 * DIM_WIDTH;
  localparam int CW = PW + 1;
  localparam logic [SEL_WIDTH:0] NB = (SEL_WIDTH + 1)'(NUM_BANKS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [SEL_WIDTH-1:0]  bank_q, bank_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DIM_WIDTH-1:0]  rows_q, rows_d;
  logic [DIM_WIDTH-1:0]  cols_q, cols_d;
  logic [PW-1:0]         expected_q, expected_d;
  logic [CW-1:0]         n_q, n_d;
  logic [ADDR_WIDTH-1:0] nxt_q, nxt_d;
  logic [DIM_WIDTH-1:0]  r_q, r_d;
  logic [DIM_WIDTH-1:0]  c_q, c_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [NUM_BANKS-1:0]  we_q, we_d;
  logic [NUM_BANKS-1:0]  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  short_q, short_d;
  logic                  sel_q, sel_d;

  logic                  tready;
  logic                  accept;
  logic                  first;
  logic [PW-1:0]         prod;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DIM_WIDTH-1:0]  r_cur, c_cur;
  logic [CW-1:0]         n_cur, n_inc;
  logic                  over, short_hit, bank_ok, done_bank_ok;

  // Tile size; only consumed on the first beat of a packet.
  assign prod = PW'(rows) * PW'(cols);

  // Handshake: ready in IDLE/ACTIVE when enabled, never in DONE or reset.
  always_comb begin
    tready = enable && (state_q != ST_DONE) && !S_AXIS_ARESET;
    accept = S_AXIS_TVALID && tready;
    first  = (state_q == ST_IDLE);
  end

  // Beat datapath: on the first beat the live sideband inputs are used
  // directly so the first write needs no extra latency.
  always_comb begin
    bank_d     = bank_q;
    mode_d     = mode_q;
    base_d     = base_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    expected_d = expected_q;
    if (first) begin
      bank_d     = bank_sel;
      mode_d     = mode;
      base_d     = base_addr;
      rows_d     = rows;
      cols_d     = cols;
      expected_d = prod;
    end

    cur_addr = first ? base_addr : nxt_q;
    r_cur    = first ? '0 : r_q;
    c_cur    = first ? '0 : c_q;
    n_cur    = first ? '0 : n_q;
    n_inc    = n_cur + CW'(1);

    over      = (n_cur >= {1'b0, expected_d});
    short_hit = S_AXIS_TLAST && (n_inc < {1'b0, expected_d});
    bank_ok   = ({1'b0, bank_d} < NB);

    // Column-major walk: step down a column by cols, then restart at the
    // top of the next column without any multiply.
    r_d   = r_cur;
    c_d   = c_cur;
    nxt_d = cur_addr + ADDR_WIDTH'(1);
    if (mode_d) begin
      if (r_cur == rows_d - DIM_WIDTH'(1)) begin
        nxt_d = base_d + ADDR_WIDTH'(c_cur) + ADDR_WIDTH'(1);
        r_d   = '0;
        c_d   = c_cur + DIM_WIDTH'(1);
      end else begin
        nxt_d = cur_addr + ADDR_WIDTH'(cols_d);
        r_d   = r_cur + DIM_WIDTH'(1);
      end
    end

    n_d = n_inc;

    we_d = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      we_d[b] = accept && bank_ok && !over && (bank_d == SEL_WIDTH'(b));
    end

    addr_d = accept ? cur_addr : addr_q;
    din_d  = accept ? S_AXIS_TDATA : din_q;

    ovf_d   = ovf_q;
    short_d = short_q;
    sel_d   = sel_q;
    if (accept) begin
      ovf_d   = (first ? 1'b0 : ovf_q)   | over;
      short_d = (first ? 1'b0 : short_q) | short_hit;
      sel_d   = (first ? 1'b0 : sel_q)   | !bank_ok;
    end
  end

  // Done pulse for the latched bank, issued as the DONE state retires.
  always_comb begin
    done_bank_ok = ({1'b0, bank_q} < NB);
    done_d = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      done_d[b] = (state_q == ST_DONE) && done_bank_ok && (bank_q == SEL_WIDTH'(b));
    end
  end

  // Packet state machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = S_AXIS_TLAST ? ST_DONE : ST_ACTIVE;
      ST_ACTIVE: if (accept && S_AXIS_TLAST) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q    <= ST_IDLE;
      bank_q     <= '0;
      mode_q     <= 1'b0;
      base_q     <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      expected_q <= '0;
      n_q        <= '0;
      nxt_q      <= '0;
      r_q        <= '0;
      c_q        <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= '0;
      done_q     <= '0;
      ovf_q      <= 1'b0;
      short_q    <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ovf_q   <= ovf_d;
      short_q <= short_d;
      sel_q   <= sel_d;
      if (accept) begin
        bank_q     <= bank_d;
        mode_q     <= mode_d;
        base_q     <= base_d;
        rows_q     <= rows_d;
        cols_q     <= cols_d;
        expected_q <= expected_d;
        n_q        <= n_d;
        nxt_q      <= nxt_d;
        r_q        <= r_d;
        c_q        <= c_d;
      end
    end
  end

  assign S_AXIS_TREADY = tready;
  assign bram_addr     = addr_q;
  assign bram_din      = din_q;
  assign bram_we       = we_q;
  assign done          = done_q;
  assign ovf_err       = ovf_q;
  assign short_err     = short_q;
  assign sel_err       = sel_q;

endmodule

// File: tb/tb_fetch_router_axis.sv
// Randomized bench for fetch_router_axis against a tile-level reference model.
module tb_fetch_router_axis;
  localparam int NB  = 3;
  localparam int SW  = 2;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int DMW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tready, enable, mode;
  logic [SW-1:0] bank_sel;
  logic [AW-1:0] base_addr, bram_addr;
  logic [DMW-1:0] rows, cols;
  logic [DW-1:0] bram_din;
  logic [NB-1:0] bram_we, done;
  logic          ovf_err, short_err, sel_err;

  int checks = 0;
  int errors = 0;

  fetch_router_axis #(
    .NUM_BANKS(NB), .SEL_WIDTH(SW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DIM_WIDTH(DMW)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TDATA(tdata),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TLAST(tlast), .S_AXIS_TREADY(tready),
    .enable(enable), .bank_sel(bank_sel), .mode(mode), .base_addr(base_addr),
    .rows(rows), .cols(cols), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_we(bram_we), .done(done), .ovf_err(ovf_err), .short_err(short_err),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tile address of beat i: row-major index for linear, column-major for transposed.
  function automatic logic [AW-1:0] model_addr(input int md, input int base, input int nr,
                                               input int nc, input int i);
    if (md == 0) return AW'(base + i);
    return AW'(base + (i % nr) * nc + (i / nr));
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_we"}, 64'(bram_we), 0);
    check({tag, "_addr"}, 64'(bram_addr), 0);
    check({tag, "_din"}, 64'(bram_din), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_flags"}, 64'({ovf_err, short_err, sel_err}), 0);
    check({tag, "_tready"}, 64'(tready), 0);
  endtask

  task automatic send_packet(input int bank, input int md, input int base, input int nr,
                             input int nc, input int nbeats, input int gap_pct,
                             input int stall_at, input int abort_after);
    longint exp_n = longint'(nr) * longint'(nc);
    int i = 0, cyc = 0, stall = 0;
    bit stalled = 0, hs, over, ovf_m = 0, short_m = 0, sel_m;
    logic [DW-1:0] data;
    logic [NB-1:0] ewe;
    sel_m = (bank >= NB);
    while (i < nbeats) begin
      @(negedge clk);
      if (i == 0) begin
        bank_sel = SW'(bank); mode = md[0]; base_addr = AW'(base);
        rows = DMW'(nr); cols = DMW'(nc);
      end else begin
        bank_sel = SW'($urandom); mode = 1'($urandom); base_addr = AW'($urandom);
        rows = DMW'($urandom); cols = DMW'($urandom);
      end
      if (i == stall_at && !stalled) begin stall = 3; stalled = 1; end
      enable = (stall == 0);
      if (stall > 0) stall--;
      tvalid = ($urandom_range(99) >= gap_pct);
      data = $urandom;
      tdata = data;
      tlast = (i == nbeats - 1);
      #1 check("tready_en", 64'(tready), 64'(enable));
      hs = tvalid && tready;
      @(posedge clk); #1;
      if (hs) begin
        over = (i >= exp_n);
        if (over) ovf_m = 1;
        if (tlast && (i + 1 < exp_n)) short_m = 1;
        ewe = (!sel_m && !over) ? NB'(1 << bank) : '0;
        check("we", 64'(bram_we), 64'(ewe));
        if (ewe != 0) begin
          check("addr", 64'(bram_addr), 64'(model_addr(md, base, nr, nc, i)));
          check("din", 64'(bram_din), 64'(data));
        end
        check("flags", 64'({ovf_err, short_err, sel_err}), 64'({ovf_m, short_m, sel_m}));
        i++;
        if (abort_after == i) begin
          @(negedge clk);
          tvalid = 1'b0; rst = 1'b1;
          @(posedge clk); #1;
          check_reset_state("rst_mid");
          @(negedge clk);
          rst = 1'b0; enable = 1'b1;
          #1 check("rst_tready", 64'(tready), 1);
          repeat (3) begin
            @(posedge clk); #1 check("rst_nodone", 64'(done), 0);
          end
          return;
        end
      end else begin
        check("we_idle", 64'(bram_we), 0);
      end
      cyc++;
      if (cyc > 1000) begin
        check("timeout", 1, 0);
        return;
      end
    end
    check("tready_done", 64'(tready), 0);
    check("done_early", 64'(done), 0);
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
    check("done", 64'(done), sel_m ? 64'(0) : 64'(1 << bank));
    check("tready_back", 64'(tready), 1);
    check("we_after", 64'(bram_we), 0);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 0);
  endtask

  initial begin
    int nr, nc, nb;
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; enable = 1'b1;
    bank_sel = '0; mode = 1'b0; base_addr = '0; rows = '0; cols = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 check("tready_post_rst", 64'(tready), 1);

    send_packet(0, 0, 0, 2, 4, 8, 0, -1, 0);       // linear bank 0
    send_packet(1, 1, 16, 3, 3, 9, 0, -1, 0);      // transposed bank 1
    send_packet(0, 0, 100, 2, 4, 8, 30, 4, 0);     // gaps and enable stall
    send_packet(1, 1, 40, 3, 3, 9, 40, 2, 0);
    send_packet(2, 0, 200, 2, 4, 6, 0, -1, 0);     // short
    send_packet(0, 1, 300, 2, 4, 10, 0, -1, 0);    // overflow
    send_packet(3, 0, 50, 2, 2, 4, 0, -1, 0);      // bad select
    send_packet(1, 0, 500, 2, 4, 8, 0, -1, 3);     // reset mid-packet
    send_packet(1, 0, 600, 2, 4, 8, 0, -1, 0);
    send_packet(2, 0, 2044, 2, 4, 8, 10, -1, 0);   // address wrap
    send_packet(0, 1, 5, 0, 3, 3, 0, -1, 0);       // rows = 0
    send_packet(2, 1, 7, 1, 1, 1, 0, -1, 0);       // single beat

    repeat (40) begin
      nr = $urandom_range(5);
      nc = $urandom_range(5);
      nb = nr * nc + $urandom_range(4) - 2;
      if (nb < 1) nb = 1;
      send_packet($urandom_range(3), $urandom_range(1), $urandom_range(2047), nr, nc, nb,
                  $urandom_range(40), $urandom_range(8) - 2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_router_axis.md
# fetch_router_axis

AXI4-Stream slave that loads configuration, kernel, input and instruction memories of the SIMD array from a DMA stream, generalising the fixed three-bank fetch unit. It routes each accepted beat to one of `NUM_BANKS` BRAM write ports, selected by `bank_sel`. It supports linear and column-major (transposed) address generation over a rows×cols tile. It checks packet length against the tile size, reports errors, and issues a per-bank done pulse to the PE controller.

## Interface
Parameters:
- `NUM_BANKS`, 4: number of BRAM targets.
- `SEL_WIDTH`, 2: width of `bank_sel`; must satisfy 2^SEL_WIDTH ≥ NUM_BANKS.
- `ADDR_WIDTH`, 11: BRAM address width, shared by all banks.
- `DATA_WIDTH`, 32: TDATA and BRAM data width.
- `DIM_WIDTH`, 16: width of `rows` and `cols`.

Ports:
- `S_AXIS_ACLK`  in  1  clock; the only clock.
- `S_AXIS_ARESET`  in  1  reset; synchronous, active-high.
- `S_AXIS_TDATA`  in  DATA_WIDTH  stream data.
- `S_AXIS_TVALID`  in  1  stream valid.
- `S_AXIS_TLAST`  in  1  last beat of packet.
- `S_AXIS_TREADY`  out  1  stream ready.
- `enable`  in  1  when low, TREADY is low.
- `bank_sel`  in  SEL_WIDTH  target bank; sampled on the first beat.
- `mode`  in  1  0 = linear, 1 = transposed; sampled on the first beat.
- `base_addr`  in  ADDR_WIDTH  start address; sampled on the first beat.
- `rows`, `cols`  in  DIM_WIDTH each  tile dimensions; sampled on the first beat.
- `bram_addr`  out  ADDR_WIDTH  registered write address, shared by all banks.
- `bram_din`  out  DATA_WIDTH  registered write data, shared by all banks.
- `bram_we`  out  NUM_BANKS  one-hot write enable.
- `done`  out  NUM_BANKS  one-cycle pulse on the bank just completed.
- `ovf_err`, `short_err`, `sel_err`  out  1 each  sticky error flags; cleared at the first beat of the next packet.

## Operation
- A beat is accepted only when TVALID & TREADY; TDATA is ignored otherwise.
- States:
  - IDLE: TREADY = enable.
  - ACTIVE: TREADY = enable.
  - DONE: TREADY = 0, lasting exactly 1 cycle.
- Transitions:
  - IDLE → ACTIVE on an accepted beat without TLAST.
  - IDLE → DONE on an accepted single-beat packet.
  - ACTIVE → DONE on an accepted TLAST beat.
  - DONE → IDLE unconditionally.
- First beat:
  - Latch `bank_sel`, `mode`, `base_addr`, `rows`, `cols`.
  - Compute `expected = rows*cols` (2·DIM_WIDTH bits, registered).
  - Clear all error flags.
  - Write to `base_addr`.
- Linear mode: each subsequent beat uses addr+1.
- Transposed mode: keep counters `r` (0..rows-1) and `c`.
  - If `r == rows-1`: next addr = `base_addr + c + 1`, set r = 0, c = c+1.
  - Otherwise: next addr = addr + cols, r = r+1.
  - No multiplier is used in the address path.
- Address arithmetic is modulo 2^ADDR_WIDTH; silent wrap, no error.
- Beat counter `n` increments on each accepted beat.
- Overflow: if a beat is accepted with n ≥ expected:
  - no write (`bram_we` = 0),
  - set `ovf_err`,
  - keep accepting until TLAST.
- Short packet: if TLAST is accepted with n+1 < expected, set `short_err`; the beats already received are written normally.
- Bad bank: if latched `bank_sel` ≥ NUM_BANKS:
  - every beat is accepted and discarded,
  - `sel_err` is set,
  - `done` stays 0 for that packet.
- `rows` == 0 or `cols` == 0: expected = 0, so every beat takes the overflow path.
- Multiple errors can assert in the same packet.

## Timing
- Reset values: TREADY=0, `bram_we`=0, `bram_addr`=0, `bram_din`=0, `done`=0, all error flags 0, state IDLE.
  - TREADY rises in the first cycle after reset deasserts (if `enable` is high).
- Write latency 1: a beat accepted at edge k drives `bram_addr`/`bram_din`/`bram_we` during cycle k..k+1; the BRAM commits at edge k+1.
- TLAST accepted at edge k:
  - cycle k+1: state DONE, last write presented, TREADY = 0.
  - cycle k+2: `done[bank]` = 1 for one cycle, state IDLE, TREADY back to enable.
- Error flags update in the same cycle that the triggering beat's write slot is presented.
- TVALID gaps: no write is issued; address and counters hold.
- `enable` dropping mid-packet: stall only; state and counters hold.
- Reset mid-packet:
  - all state is cleared at the next edge,
  - any pending write is cancelled (`bram_we` = 0 in the following cycle),
  - no `done` pulse is issued.
- Throughput: 1 beat per cycle within a packet; 1 bubble cycle between packets.

## Test plan
- Linear load, bank 0: base=0, rows=2, cols=4, 8 beats D0..D7 with TLAST on D7 →
  - addresses 0..7 with data D0..D7, `bram_we` = 4'b0001,
  - `done` = 4'b0001 two cycles after the TLAST handshake,
  - no error flags.
- Transposed load, bank 1: rows=3, cols=3, base=16, 9 beats →
  - address order 16, 19, 22, 17, 20, 23, 18, 21, 24,
  - `done[1]` pulses.
- Backpressure and gaps: random TVALID gaps, `enable` low for 3 cycles mid-packet →
  - write sequence identical to the gap-free run,
  - TREADY low while `enable` is low,
  - TREADY low for exactly 1 cycle after TLAST.
- Length errors:
  - 6 beats sent against expected=8 → `short_err`=1, 6 writes, `done` pulses.
  - 10 beats sent against expected=8 → `ovf_err`=1, exactly 8 writes.
  - Both flags clear on the next packet's first beat.
- Bad select with NUM_BANKS=3: `bank_sel`=3, 4 beats → all accepted, `bram_we` stays 0, `sel_err`=1, `done`=0.
- Reset mid-packet: assert reset after beat 3 of 8 → all outputs return to reset values, no `done` pulse; the next packet starts at its own `base_addr`.
